// File: rtl/qspi_flash_responder.sv
// SPI/QSPI NOR-flash responder: 4-byte-address std/dual/quad reads plus die select.
// Optional quad-output path is built only when QSPI_RESP_QUAD_EN is defined.
`timescale 1ns/1ps
module qspi_flash_responder #(
  parameter int DIE_ADDR_W   = 25,
  parameter int DUMMY_CYCLES = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  system_clk,
  input  logic                  system_reset_n,
  input  logic                  spi_clk,
  input  logic                  cs_n,
  input  logic                  io0_in,
  output logic                  io0_out,
  output logic                  io1_out,
  output logic                  io2_out,
  output logic                  io3_out,
  output logic                  io0_oe,
  output logic                  io1_oe,
  output logic                  io2_oe,
  output logic                  io3_oe,
  output logic                  data_req,
  output logic [DIE_ADDR_W-1:0] data_addr,
  input  logic [7:0]            data_in,
  output logic                  die_sel,
  output logic                  busy
);

`ifdef QSPI_RESP_QUAD_EN
  localparam int IO_W = 4;
`else
  localparam int IO_W = 2;
`endif

  // Synchronizer bundle order is {io0, cs_n, spi_clk}; cs_n resets high so busy starts low.
  localparam logic [2:0] SYNC_RST = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DIESEL, S_IGNORE
  } state_t;

  typedef enum logic [1:0] {M_STD, M_DUAL, M_QUAD} mode_t;

  logic [2:0] sync_out;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic [2:0] q_reg;
      logic [2:0] d;
      if (gi == 0) begin : g_first
        assign d = {io0_in, cs_n, spi_clk};
      end else begin : g_rest
        assign d = g_sync[gi-1].q_reg;
      end
      always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) q_reg <= SYNC_RST;
        else                 q_reg <= d;
      end
    end
  endgenerate

  assign sync_out = g_sync[SYNC_STAGES-1].q_reg;

  logic sclk_s, cs_s, io0_s;
  assign sclk_s = sync_out[0];
  assign cs_s   = sync_out[1];
  assign io0_s  = sync_out[2];

  state_t                state_reg, state_next;
  mode_t                 mode_reg, mode_next;
  logic [5:0]            cnt_reg, cnt_next;
  logic [DIE_ADDR_W-2:0] shift_in_reg, shift_in_next;
  logic [DIE_ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]            byte_buf_reg, byte_buf_next;
  logic [7:0]            tx_shift_reg, tx_shift_next;
  logic [2:0]            grp_reg, grp_next;
  logic                  load_now_reg, load_now_next;
  logic                  data_req_reg, data_req_next;
  logic                  die_sel_reg, die_sel_next;
  logic [IO_W-1:0]       io_out_reg, io_out_next;
  logic [IO_W-1:0]       io_oe_reg, io_oe_next;
  logic                  sclk_prev_reg, cs_prev_reg;

  logic                  sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [7:0]            cur_byte, byte_src;
  logic [DIE_ADDR_W-2:0] shift_word;
  logic [2:0]            grp_last;

  // Edges are only meaningful while the synchronized chip select is low.
  assign sclk_rise = sclk_s & ~sclk_prev_reg & ~cs_s;
  assign sclk_fall = ~sclk_s & sclk_prev_reg & ~cs_s;
  assign cs_fall   = ~cs_s & cs_prev_reg;
  assign cs_rise   = cs_s & ~cs_prev_reg;

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_reg     <= S_IDLE;
      mode_reg      <= M_STD;
      cnt_reg       <= '0;
      shift_in_reg  <= '0;
      addr_reg      <= '0;
      byte_buf_reg  <= '0;
      tx_shift_reg  <= '0;
      grp_reg       <= '0;
      load_now_reg  <= 1'b0;
      data_req_reg  <= 1'b0;
      die_sel_reg   <= 1'b0;
      io_out_reg    <= '0;
      io_oe_reg     <= '0;
      sclk_prev_reg <= 1'b0;
      cs_prev_reg   <= 1'b1;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      cnt_reg       <= cnt_next;
      shift_in_reg  <= shift_in_next;
      addr_reg      <= addr_next;
      byte_buf_reg  <= byte_buf_next;
      tx_shift_reg  <= tx_shift_next;
      grp_reg       <= grp_next;
      load_now_reg  <= load_now_next;
      data_req_reg  <= data_req_next;
      die_sel_reg   <= die_sel_next;
      io_out_reg    <= io_out_next;
      io_oe_reg     <= io_oe_next;
      sclk_prev_reg <= sclk_s;
      cs_prev_reg   <= cs_s;
    end
  end

  always_comb begin
    state_next    = state_reg;
    mode_next     = mode_reg;
    cnt_next      = cnt_reg;
    shift_in_next = shift_in_reg;
    addr_next     = addr_reg;
    tx_shift_next = tx_shift_reg;
    grp_next      = grp_reg;
    die_sel_next  = die_sel_reg;
    io_out_next   = io_out_reg;
    io_oe_next    = io_oe_reg;
    data_req_next = 1'b0;
    load_now_next = data_req_reg;
    grp_last      = 3'd7;
    // The fetched byte may arrive in the same cycle as the first falling edge, so bypass it.
    cur_byte      = load_now_reg ? data_in : byte_buf_reg;
    byte_buf_next = cur_byte;
    byte_src      = (grp_reg == 3'd0) ? cur_byte : tx_shift_reg;
    shift_word    = {shift_in_reg[DIE_ADDR_W-3:0], io0_s};

    if (cs_rise) begin
      state_next  = S_IDLE;
      cnt_next    = '0;
      io_out_next = '0;
      io_oe_next  = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cs_fall) begin
            state_next = S_CMD;
            cnt_next   = '0;
          end
        end
        S_CMD: begin
          if (sclk_rise) begin
            shift_in_next = shift_word;
            cnt_next      = cnt_reg + 6'd1;
            if (cnt_reg == 6'd7) begin
              cnt_next = '0;
              case (shift_word[7:0])
                8'h13: begin mode_next = M_STD;  state_next = S_ADDR; end
                8'h3C: begin mode_next = M_DUAL; state_next = S_ADDR; end
`ifdef QSPI_RESP_QUAD_EN
                8'h6C: begin mode_next = M_QUAD; state_next = S_ADDR; end
`endif
                8'hC2:   state_next = S_DIESEL;
                default: state_next = S_IGNORE;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (sclk_rise) begin
            shift_in_next = shift_word;
            cnt_next      = cnt_reg + 6'd1;
            if (cnt_reg == 6'd31) begin
              // Only the low DIE_ADDR_W address bits survive in the shifter.
              addr_next     = {shift_in_reg, io0_s};
              data_req_next = 1'b1;
              grp_next      = '0;
              cnt_next      = '0;
              state_next    = (mode_reg == M_STD) ? S_DATA : S_DUMMY;
            end
          end
        end
        S_DUMMY: begin
          if (sclk_rise) begin
            cnt_next = cnt_reg + 6'd1;
            if (cnt_reg == 6'(DUMMY_CYCLES - 1)) begin
              cnt_next   = '0;
              state_next = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (sclk_fall) begin
            io_out_next = '0;
            io_oe_next  = '0;
            case (mode_reg)
              M_DUAL: begin
                io_out_next[1:0] = byte_src[7:6];
                io_oe_next[1:0]  = 2'b11;
                tx_shift_next    = {byte_src[5:0], 2'b00};
                grp_last         = 3'd3;
              end
`ifdef QSPI_RESP_QUAD_EN
              M_QUAD: begin
                io_out_next   = byte_src[7:4];
                io_oe_next    = 4'hF;
                tx_shift_next = {byte_src[3:0], 4'h0};
                grp_last      = 3'd1;
              end
`endif
              default: begin
                io_out_next[1] = byte_src[7];
                io_oe_next[1]  = 1'b1;
                tx_shift_next  = {byte_src[6:0], 1'b0};
                grp_last       = 3'd7;
              end
            endcase
            grp_next = (grp_reg == grp_last) ? 3'd0 : grp_reg + 3'd1;
            // Prefetch the following byte while the current one shifts out; wraps inside the die.
            if (grp_reg == 3'd0) begin
              addr_next     = addr_reg + {{(DIE_ADDR_W-1){1'b0}}, 1'b1};
              data_req_next = 1'b1;
            end
          end
        end
        S_DIESEL: begin
          if (sclk_rise) begin
            cnt_next = cnt_reg + 6'd1;
            if (cnt_reg == 6'd7) begin
              die_sel_next = io0_s;
              cnt_next     = '0;
              state_next   = S_IGNORE;
            end
          end
        end
        S_IGNORE: begin
          io_oe_next = '0;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign io0_out   = io_out_reg[0];
  assign io1_out   = io_out_reg[1];
  assign io0_oe    = io_oe_reg[0];
  assign io1_oe    = io_oe_reg[1];
`ifdef QSPI_RESP_QUAD_EN
  assign io2_out   = io_out_reg[2];
  assign io3_out   = io_out_reg[3];
  assign io2_oe    = io_oe_reg[2];
  assign io3_oe    = io_oe_reg[3];
`else
  assign io2_out   = 1'b0;
  assign io3_out   = 1'b0;
  assign io2_oe    = 1'b0;
  assign io3_oe    = 1'b0;
`endif
  assign data_req  = data_req_reg;
  assign data_addr = addr_reg;
  assign die_sel   = die_sel_reg;
  assign busy      = ~cs_s;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for qspi_flash_responder: std/dual/quad reads, wrap, die select, abort, reset.
`timescale 1ns/1ps
module tb_qspi_flash_responder;

  logic        system_clk = 1'b0;
  logic        system_reset_n;
  logic        spi_clk, cs_n, io0_in;
  logic        io0_out, io1_out, io2_out, io3_out;
  logic        io0_oe, io1_oe, io2_oe, io3_oe;
  logic        data_req;
  logic [24:0] data_addr;
  logic [7:0]  data_in = 8'h00;
  logic        die_sel, busy;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          req_cnt = 0;
  int          consec_cnt = 0;
  logic        req_prev = 1'b0;
  logic [24:0] req_log [0:63];
  int          mem_kind = 0;
  int          req_base;
  int          oe_bad;
  int          n_req;
  logic [7:0]  rx [0:15];
  logic [3:0]  s_io, s_oe;

  always #5 system_clk = ~system_clk;

  qspi_flash_responder dut (
    .system_clk(system_clk), .system_reset_n(system_reset_n),
    .spi_clk(spi_clk), .cs_n(cs_n), .io0_in(io0_in),
    .io0_out(io0_out), .io1_out(io1_out), .io2_out(io2_out), .io3_out(io3_out),
    .io0_oe(io0_oe), .io1_oe(io1_oe), .io2_oe(io2_oe), .io3_oe(io3_oe),
    .data_req(data_req), .data_addr(data_addr), .data_in(data_in),
    .die_sel(die_sel), .busy(busy)
  );

  function automatic logic [7:0] mem_val(input logic [24:0] a);
    case (mem_kind)
      1:       return 8'hEE;
      2:       return 8'hBD;
      default: return 8'(8'hAA + a[7:0] - 8'hBB);
    endcase
  endfunction

  // Backing store: byte is valid on the cycle after the strobe.
  always @(posedge system_clk) begin
    if (data_req) begin
      data_in <= mem_val(data_addr);
      if (req_cnt < 64) req_log[req_cnt] = data_addr;
      req_cnt = req_cnt + 1;
    end
    if (data_req && req_prev) consec_cnt = consec_cnt + 1;
    req_prev = data_req;
  end

  function automatic logic [3:0] oe_vec();
    return {io3_oe, io2_oe, io1_oe, io0_oe};
  endfunction

  function automatic logic [3:0] io_vec();
    return {io3_out, io2_out, io1_out, io0_out};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One mode-0 clock: drive io0 in the low phase, sample DUT outputs just before the rise.
  task automatic sclk(input logic b, output logic [3:0] io, output logic [3:0] oe);
    io0_in = b;
    #40;
    io = io_vec();
    oe = oe_vec();
    spi_clk = 1'b1;
    #40;
    spi_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic [3:0] io, oe;
    for (int i = n - 1; i >= 0; i--) sclk(v[i], io, oe);
  endtask

  task automatic start_cmd(input logic [7:0] cmd, input logic [31:0] addr);
    cs_n = 1'b0;
    #40;
    send_bits({24'h0, cmd}, 8);
    send_bits(addr, 32);
  endtask

  task automatic cs_end();
    #40;
    cs_n = 1'b1;
    #80;
  endtask

  task automatic read_bytes(input int w, input int n, input logic [3:0] exp_oe);
    logic [3:0] io, oe;
    logic [7:0] b;
    oe_bad = 0;
    for (int k = 0; k < n; k++) begin
      b = 8'h00;
      for (int g = 0; g < 8 / w; g++) begin
        sclk(1'b0, io, oe);
        if (oe !== exp_oe) oe_bad++;
        case (w)
          1:       b = {b[6:0], io[1]};
          2:       b = {b[5:0], io[1:0]};
          default: b = {b[3:0], io[3:0]};
        endcase
      end
      rx[k] = b;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    system_reset_n = 1'b0;
    cs_n = 1'b1;
    spi_clk = 1'b0;
    io0_in = 1'b0;
    #22;
    check("rst_oe", 32'(oe_vec()), 0);
    check("rst_out", 32'(io_vec()), 0);
    check("rst_req", 32'(data_req), 0);
    check("rst_addr", 32'(data_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_die", 32'(die_sel), 0);
    system_reset_n = 1'b1;
    #40;

    // Standard read from 0xBB.
    mem_kind = 0;
    req_base = req_cnt;
    cs_n = 1'b0;
    #40;
    check("std_busy", 32'(busy), 1);
    cs_n = 1'b1;
    #40;
    start_cmd(8'h13, 32'h0000_00BB);
    read_bytes(1, 12, 4'b0010);
    cs_end();
    check("std_oe", oe_bad, 0);
    check("std_busy_end", 32'(busy), 0);
    for (int k = 0; k < 12; k++) begin
      check("std_byte", 32'(rx[k]), 32'(8'hAA + k));
      check("std_addr", 32'(req_log[req_base + k]), 32'h0BB + k);
    end
    $display("[TB] std read addr=0xBB bytes=12 first=%h last=%h", rx[0], rx[11]);

    // Dual read from 0xCC with dummy phase.
    mem_kind = 1;
    req_base = req_cnt;
    start_cmd(8'h3C, 32'h0000_00CC);
    oe_bad = 0;
    for (int d = 0; d < 8; d++) begin
      sclk(1'b0, s_io, s_oe);
      if (s_oe !== 4'b0000) oe_bad++;
    end
    check("dual_dummy_oe", oe_bad, 0);
    read_bytes(2, 12, 4'b0011);
    cs_end();
    check("dual_oe", oe_bad, 0);
    for (int k = 0; k < 12; k++) check("dual_byte", 32'(rx[k]), 32'hEE);
    check("dual_addr0", 32'(req_log[req_base]), 32'h0CC);
    $display("[TB] dual read addr=0xCC bytes=12 first=%h", rx[0]);

    // Quad read from 0xDD.
    mem_kind = 2;
    req_base = req_cnt;
    start_cmd(8'h6C, 32'h0000_00DD);
    oe_bad = 0;
    for (int d = 0; d < 8; d++) begin
      sclk(1'b0, s_io, s_oe);
      if (s_oe !== 4'b0000) oe_bad++;
    end
    check("quad_dummy_oe", oe_bad, 0);
`ifdef QSPI_RESP_QUAD_EN
    read_bytes(4, 12, 4'b1111);
    cs_end();
    check("quad_oe", oe_bad, 0);
    for (int k = 0; k < 12; k++) check("quad_byte", 32'(rx[k]), 32'hBD);
    check("quad_addr0", 32'(req_log[req_base]), 32'h0DD);
`else
    read_bytes(4, 12, 4'b0000);
    cs_end();
    check("quad_off_oe", oe_bad, 0);
    check("quad_off_req", req_cnt - req_base, 0);
`endif
    $display("[TB] quad read addr=0xDD bytes=12 first=%h", rx[0]);

    // Address wrap at the die boundary.
    mem_kind = 0;
    req_base = req_cnt;
    start_cmd(8'h13, 32'h01FF_FFFA);
    read_bytes(1, 8, 4'b0010);
    cs_end();
    for (int k = 0; k < 8; k++)
      check("wrap_addr", 32'(req_log[req_base + k]), (32'h1FF_FFFA + k) & 32'h1FF_FFFF);
    check("wrap_die", 32'(die_sel), 0);
    $display("[TB] wrap read addr=0x1FFFFFA bytes=8");

    // Die select, aborted die select, unknown command.
    cs_n = 1'b0;
    #40;
    send_bits(32'hC2, 8);
    send_bits(32'h01, 8);
    cs_end();
    check("die_set", 32'(die_sel), 1);
    $display("[TB] die select 0x01 die_sel=%0d", die_sel);
    cs_n = 1'b0;
    #40;
    send_bits(32'hC2, 8);
    send_bits(32'h00, 5);
    cs_end();
    check("die_abort", 32'(die_sel), 1);
    $display("[TB] die select aborted die_sel=%0d", die_sel);
    req_base = req_cnt;
    cs_n = 1'b0;
    #40;
    send_bits(32'h9F, 8);
    read_bytes(1, 4, 4'b0000);
    cs_end();
    check("unk_oe", oe_bad, 0);
    check("unk_req", req_cnt - req_base, 0);
    $display("[TB] unknown command 0x9F");

    // Abort after the third data bit.
    req_base = req_cnt;
    start_cmd(8'h13, 32'h0000_0010);
    for (int i = 0; i < 3; i++) sclk(1'b0, s_io, s_oe);
    #10;
    cs_n = 1'b1;
    #35;
    check("abort_oe", 32'(oe_vec()), 0);
    check("abort_busy", 32'(busy), 0);
    n_req = req_cnt;
    for (int i = 0; i < 4; i++) sclk(1'b0, s_io, s_oe);
    #80;
    check("abort_noreq", req_cnt - n_req, 0);
    check("abort_req_total", req_cnt - req_base, 2);
    check("abort_oe_idle", 32'(oe_vec()), 0);
    $display("[TB] std read aborted after 3 bits");
    req_base = req_cnt;
    start_cmd(8'h13, 32'h0000_0020);
    read_bytes(1, 2, 4'b0010);
    cs_end();
    check("post_byte0", 32'(rx[0]), 32'h0F);
    check("post_byte1", 32'(rx[1]), 32'h10);
    check("post_addr0", 32'(req_log[req_base]), 32'h020);
    $display("[TB] std read after abort addr=0x20 bytes=%h %h", rx[0], rx[1]);

    // Asynchronous reset in the middle of a data phase.
    start_cmd(8'h13, 32'h0000_0040);
    for (int i = 0; i < 3; i++) sclk(1'b0, s_io, s_oe);
    #13;
    system_reset_n = 1'b0;
    #1;
    check("arst_oe", 32'(oe_vec()), 0);
    check("arst_addr", 32'(data_addr), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_die", 32'(die_sel), 0);
    cs_n = 1'b1;
    #26;
    system_reset_n = 1'b1;
    #40;
    $display("[TB] async reset mid-transfer");

    check("req_gap", consec_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/qspi_flash_responder.md
Name: qspi_flash_responder

Overview:
- Synthesizable SPI/QSPI NOR-flash responder: the flash end of the bus that the QSPI read controller drives.
- Decodes 4-byte-address read commands (standard, dual-output, quad-output) and the die-select command.
- Drives read data onto io0..io3 from a byte-wide backing-store interface.
- Used as an on-FPGA loopback target and as a bench model for controller regression.

Parameters:
- DIE_ADDR_W, 25, address bits per die (32 MB die); the data address wraps inside a die.
- DUMMY_CYCLES, 8, spi_clk cycles between the last address bit and the first data bit for dual and quad reads. Standard read uses 0.
- SYNC_STAGES, 2, synchronizer depth on spi_clk, cs_n and io0.

Ports:
- system_clk  in  1  system clock; all logic is on its rising edge.
- system_reset_n  in  1  asynchronous active-low reset.
- spi_clk  in  1  SPI clock from the controller (mode 0); must be at most system_clk/4.
- cs_n  in  1  chip select, active low.
- io0_in  in  1  MOSI / io0 sampled value.
- io0_out, io1_out, io2_out, io3_out  out  1 each  drive values.
- io0_oe, io1_oe, io2_oe, io3_oe  out  1 each  output enables; the top level builds the tristates.
- data_req  out  1  one-cycle fetch strobe.
- data_addr  out  DIE_ADDR_W  byte address for the fetch; valid while data_req is high.
- data_in  in  8  fetched byte; must be valid on the cycle after data_req.
- die_sel  out  1  currently selected die.
- busy  out  1  high while cs_n is synchronized low.

Behaviour:
- Reset values: all io*_out, io*_oe, data_req, data_addr and busy are 0. die_sel is 0.
- Input sync: spi_clk, cs_n and io0_in pass through SYNC_STAGES flip-flops. Edges are detected on the synchronized spi_clk.
  - Sampling uses the synchronized io0 at a rising edge.
  - Outputs update on the cycle a falling edge is detected.
  - Output latency is SYNC_STAGES+1 system_clk cycles after the physical spi_clk edge.
- The FSM advances only on detected spi_clk edges while cs_n is low. States:
  - IDLE: on cs_n falling, go to CMD with bit count 0.
  - CMD: shift 8 bits, MSB first, from io0. After the 8th bit:
    - 0x13 sets mode STD and goes to ADDR.
    - 0x3C sets mode DUAL and goes to ADDR.
    - 0x6C sets mode QUAD and goes to ADDR.
    - 0xC2 goes to DIESEL.
    - Any other value goes to IGNORE.
  - ADDR: shift 32 bits, MSB first. After the 32nd bit, latch addr[DIE_ADDR_W-1:0]; upper bits are ignored. Then:
    - Issue data_req with data_addr = the latched address.
    - Load data_in into the shift register on the next cycle.
    - Go to DATA for STD, or to DUMMY for DUAL/QUAD.
  - DUMMY: count DUMMY_CYCLES rising edges, then go to DATA. All oe stay 0.
  - DATA: on each falling edge, present the next bits of the byte.
    - STD: io1 only, MSB first; io1_oe = 1.
    - DUAL: {io1,io0} = bits [7:6], [5:4], [3:2], [1:0]; io0_oe and io1_oe = 1.
    - QUAD: {io3,io2,io1,io0} = high nibble, then low nibble; all four oe = 1.
    - When the first bit-group of a byte is driven: increment the address, wrapping from 2^DIE_ADDR_W-1 to 0 with no die change; issue data_req; load the next byte before that byte's final group completes.
    - DATA continues indefinitely until cs_n rises.
  - DIESEL: shift 8 bits. After the 8th bit, set die_sel = bit 0 and go to IGNORE.
  - IGNORE: hold all oe at 0 and discard edges.
- cs_n rising, in any state, when detected:
  - Go to IDLE.
  - Force all oe to 0 in the same cycle.
  - Discard any partial command, address or die byte (die_sel keeps its last committed value).
- Simultaneous cs_n rise and spi_clk edge: cs_n wins and the edge is ignored.
- A spi_clk edge with cs_n high is ignored.
- Asynchronous reset mid-transfer returns the block immediately to the reset values above.
- In STD mode the first data bit is driven on the falling edge immediately after the rising edge that sampled the last address bit.
- data_req is never high on two consecutive cycles.

Optional Feature:
- Macro QSPI_RESP_QUAD_EN.
  - Defined: command 0x6C is decoded as quad read and io2/io3 are driven as specified.
  - Undefined: 0x6C goes to IGNORE. io2_out, io3_out, io2_oe and io3_oe are tied to 0, and the quad datapath is not built.

Test Plan:
- Standard read: cs_n low, send 0x13 then address 0x000000BB; backing store returns 0xAA+n at address 0xBB+n; clock 12 bytes.
  - Expect data_addr 0xBB..0xC6 in order.
  - Expect io1 serial bytes 0xAA, 0xAB, … MSB first, with io1_oe = 1 only.
- Dual read: 0x3C, address 0x000000CC, 8 dummy clocks, then 12 bytes of constant 0xEE.
  - Expect io1/io0 pairs 11, 10, 11, 10 per byte.
  - Expect oe to be 0 through the dummy phase and 1 from the first data falling edge.
- Quad read (QSPI_RESP_QUAD_EN defined): 0x6C, address 0x000000DD, 12 bytes of 0xBD.
  - Expect nibbles 1011 then 1101 on io3..io0.
  - Rebuild without the macro: same stimulus gives all oe = 0 throughout.
- Wrap: 0x13 with address 0x01FFFFFA, clock 8 bytes.
  - Expect data_addr 0x1FFFFFA..0x1FFFFFF, then 0x0000000, 0x0000001.
  - Expect die_sel unchanged at 0.
- Die select: send 0xC2, 0x01 → die_sel = 1 after cs_n rises.
  - Then 0xC2 followed by only 5 bits with cs_n aborting → die_sel stays 1.
  - Unknown command 0x9F → no oe asserted and no data_req.
- Abort: raise cs_n after the 3rd data bit of a standard read.
  - Expect all oe = 0 within SYNC_STAGES+1 cycles, busy = 0, and no further data_req.
  - The next transaction decodes normally.
